// File: rtl/regfile_pkg.sv
// regfile_sb shared types: sweep FSM state, default sizes, zero-register index.
// Imported by the interface, the scoreboard and the top.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_ZERO  = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb port bundle: read ports, writeback, issue, init status.
// master drives ra/we/wa/wd/iss_*; slave returns rd/rbusy/wr_old/init_busy.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(DEPTH)
);

  logic [NREAD-1:0][AW-1:0]    ra;
  logic [NREAD-1:0][WIDTH-1:0] rd;
  logic [NREAD-1:0]            rbusy;
  logic                        we;
  logic [AW-1:0]               wa;
  logic [WIDTH-1:0]            wd;
  logic [WIDTH-1:0]            wr_old;
  logic                        iss_valid;
  logic [AW-1:0]               iss_addr;
  logic                        init_busy;

  modport master (
    output ra, we, wa, wd,
    output iss_valid, iss_addr,
    input  rd, rbusy, wr_old,
    input  init_busy
  );

  modport slave (
    input  ra, we, wa, wd,
    input  iss_valid, iss_addr,
    output rd, rbusy, wr_old,
    output init_busy
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: DEPTH bits, async clear, set/clear, NREAD lookups.
// Ports: clk, rst, set_en/set_addr, clr_en/clr_addr, ra (lookups), busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [AW-1:0]            set_addr,
  input  logic                     clr_en,
  input  logic [AW-1:0]            clr_addr,
  input  logic [NREAD-1:0][AW-1:0] ra,
  output logic [NREAD-1:0]         busy
);

  logic [DEPTH-1:0] bits;

  // Set beats clear so a new producer issued in the
  // writeback cycle keeps the register reserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits <= '0;
    end else begin
      bits[RF_ZERO] <= 1'b0;
      for (int i = RF_ZERO + 1; i < DEPTH; i++) begin
        if (set_en && set_addr == AW'(i))
          bits[i] <= 1'b1;
        else if (clr_en && clr_addr == AW'(i))
          bits[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NREAD; i++)
      busy[i] = bits[ra[i]];
  end

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file with post-reset zeroing sweep.
// Ports: clk, rst, bus (regfile_sb_if.slave). Option: REGFILE_SB_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int NREAD = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO = AW'(RF_ZERO);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e        state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] rf [DEPTH];
  logic             run;
  logic             wen;
  logic             set_en;
  logic [NREAD-1:0] sb_busy;
  logic [NREAD-1:0] fwd;

  assign run    = (state == RF_RUN);
  assign wen    = run && bus.we && (bus.wa != ZERO);
  assign set_en = run && bus.iss_valid &&
                  (bus.iss_addr != ZERO);

  // Sweep counter starts at 1: entry 0 is hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RF_INIT;
      cnt           <= AW'(1);
      bus.init_busy <= 1'b1;
    end else if (!run) begin
      cnt <= cnt + AW'(1);
      if (cnt == LAST) begin
        state         <= RF_RUN;
        bus.init_busy <= 1'b0;
      end
    end
  end

  // Reset-less storage; the sweep supplies the zeroes.
  always_ff @(posedge clk) begin
    if (!run)
      rf[cnt] <= '0;
    else if (wen)
      rf[bus.wa] <= bus.wd;
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_addr (bus.iss_addr),
    .clr_en   (wen),
    .clr_addr (bus.wa),
    .ra       (bus.ra),
    .busy     (sb_busy)
  );

  always_comb begin
    fwd = '0;
`ifdef REGFILE_SB_BYPASS_EN
    for (int i = 0; i < NREAD; i++)
      fwd[i] = wen && (bus.wa == bus.ra[i]);
`endif
  end

  always_comb begin
    bus.rd    = '0;
    bus.rbusy = '1;
    if (run) begin
      for (int i = 0; i < NREAD; i++) begin
        if (fwd[i]) begin
          bus.rd[i]    = bus.wd;
          bus.rbusy[i] = set_en &&
                         (bus.iss_addr == bus.wa);
        end else begin
          bus.rd[i]    = (bus.ra[i] == ZERO) ? '0
                         : rf[bus.ra[i]];
          bus.rbusy[i] = sb_busy[i];
        end
      end
    end
  end

  assign bus.wr_old = (run && bus.wa != ZERO)
                      ? rf[bus.wa] : '0;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (DEPTH=32, NREAD=2).
// Linear steps; hand-computed expectations checked by assertions.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  int   n;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus ();

  regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0;
    bus.iss_valid = 1'b0;
  endtask

  // Counts edges until init_busy falls, bounded.
  task automatic sweep(output int cnt);
    cnt = 0;
    while (bus.init_busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    bus.ra = '0;
    bus.ra[0] = 5'd5;
    bus.wa = 5'd5;
    bus.wd = '0;
    bus.iss_addr = '0;
    idle();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_busy", bus.init_busy, 1);
    chk("rst_rd0", bus.rd[0], 0);
    chk("rst_rbusy", bus.rbusy, 2'b11);
    chk("rst_wr_old", bus.wr_old, 0);

    rst = 1'b0;
    sweep(n);
    chk("sweep_len", n, 31);

    // Every entry zeroed, nothing busy
    for (int a = 1; a < 32; a++) begin
      bus.ra[0] = 5'(a);
      bus.ra[1] = 5'(32 - a);
      @(negedge clk);
      chk("zero_rd0", bus.rd[0], 0);
      chk("zero_rd1", bus.rd[1], 0);
      chk("zero_rbusy", bus.rbusy, 0);
    end

    // Write 5
    tick();
    bus.ra[0] = 5'd5;
    bus.we = 1'b1;
    bus.wa = 5'd5;
    bus.wd = 32'hDEADBEEF;
    @(negedge clk);
    chk("w5_old_pre", bus.wr_old, 0);
`ifdef REGFILE_SB_BYPASS_EN
    chk("w5_fwd", bus.rd[0], 32'hDEADBEEF);
`else
    chk("w5_nofwd", bus.rd[0], 0);
`endif
    tick();
    idle();
    @(negedge clk);
    chk("w5_rd", bus.rd[0], 32'hDEADBEEF);
    chk("w5_old", bus.wr_old, 32'hDEADBEEF);
    tick();
    bus.we = 1'b1;
    bus.wd = 32'h11;
    @(negedge clk);
    chk("w5_old_hold", bus.wr_old, 32'hDEADBEEF);
    tick();
    idle();
    @(negedge clk);
    chk("w5_rd2", bus.rd[0], 32'h11);

    // Register 0
    tick();
    bus.ra = '0;
    bus.we = 1'b1;
    bus.wa = 5'd0;
    bus.wd = 32'h1234;
    bus.iss_valid = 1'b1;
    bus.iss_addr = 5'd0;
    tick();
    idle();
    @(negedge clk);
    chk("r0_rd", bus.rd[0], 0);
    chk("r0_rbusy", bus.rbusy, 0);
    chk("r0_wr_old", bus.wr_old, 0);

    // Issue then writeback on 7
    tick();
    bus.ra[1] = 5'd7;
    bus.iss_valid = 1'b1;
    bus.iss_addr = 5'd7;
    @(negedge clk);
    chk("i7_same", bus.rbusy[1], 0);
    tick();
    idle();
    @(negedge clk);
    chk("i7_busy", bus.rbusy[1], 1);
    chk("i7_rd", bus.rd[1], 0);
    tick();
    bus.we = 1'b1;
    bus.wa = 5'd7;
    bus.wd = 32'hA5A5A5A5;
    @(negedge clk);
`ifdef REGFILE_SB_BYPASS_EN
    chk("w7_fwd_busy", bus.rbusy[1], 0);
    chk("w7_fwd_rd", bus.rd[1], 32'hA5A5A5A5);
`else
    chk("w7_pre_busy", bus.rbusy[1], 1);
    chk("w7_pre_rd", bus.rd[1], 0);
`endif
    tick();
    idle();
    @(negedge clk);
    chk("w7_busy", bus.rbusy[1], 0);
    chk("w7_rd", bus.rd[1], 32'hA5A5A5A5);

    // Simultaneous issue + write on 9
    tick();
    bus.ra[0] = 5'd9;
    bus.we = 1'b1;
    bus.wa = 5'd9;
    bus.wd = 32'h55;
    bus.iss_valid = 1'b1;
    bus.iss_addr = 5'd9;
    @(negedge clk);
`ifdef REGFILE_SB_BYPASS_EN
    chk("s9_fwd_busy", bus.rbusy[0], 1);
    chk("s9_fwd_rd", bus.rd[0], 32'h55);
`else
    chk("s9_pre_busy", bus.rbusy[0], 0);
    chk("s9_pre_rd", bus.rd[0], 0);
`endif
    tick();
    idle();
    @(negedge clk);
    chk("s9_busy", bus.rbusy[0], 1);
    chk("s9_rd", bus.rd[0], 32'h55);
    tick();
    bus.we = 1'b1;
    bus.wd = 32'h66;
    tick();
    idle();
    @(negedge clk);
    chk("w9_busy", bus.rbusy[0], 0);
    chk("w9_rd", bus.rd[0], 32'h66);

    // Reset while 3 is busy
    tick();
    bus.ra[0] = 5'd3;
    bus.iss_valid = 1'b1;
    bus.iss_addr = 5'd3;
    tick();
    idle();
    @(negedge clk);
    chk("i3_busy", bus.rbusy[0], 1);
    tick();
    rst = 1'b1;
    bus.we = 1'b1;
    bus.wa = 5'd3;
    bus.wd = 32'hFFFFFFFF;
    bus.iss_valid = 1'b1;
    #1;
    chk("rr_rbusy", bus.rbusy, 2'b11);
    chk("rr_init", bus.init_busy, 1);
    chk("rr_rd", bus.rd[0], 0);
    chk("rr_wr_old", bus.wr_old, 0);
    @(negedge clk);
    rst = 1'b0;
    sweep(n);
    chk("resweep_len", n, 31);
    idle();
    @(negedge clk);
    chk("rr_busy3", bus.rbusy[0], 0);
    chk("rr_rd3", bus.rd[0], 0);
    chk("rr_old3", bus.wr_old, 0);

    // First RUN write after sweep
    tick();
    bus.we = 1'b1;
    bus.wd = 32'h77;
    tick();
    idle();
    @(negedge clk);
    chk("post_rd3", bus.rd[0], 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
